// File: rtl/dm_pkg.sv
// dm_pkg: shared types and helpers for the burst data memory.
//   state_e : controller states (CLEAR, IDLE, WAIT, BURST)
//   clog2   : constant function used to size the line offset (OFF_W)
package dm_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_BURST = 2'd3
   } state_e;

   // Ceiling log2 usable in localparam expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/dm_array.sv
// dm_array: DEPTH x DATA_W single-port word array.
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address (combinational read, captured by the
//           owner's response register)
//   rdata : read data
// INIT_PATTERN selects the power-up contents: 0 = all zero, 1 = mem[i] = i.
module dm_array #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 15,
   parameter int INIT_PATTERN = 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Power-up image only; reset never re-applies it.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = (INIT_PATTERN == 1) ? DATA_W'(i) : '0;
      end
   end

   // NOTE: the array has no reset term so it maps onto RAM; clearing is
   // done explicitly by the owner's clear sequencer, one word per cycle.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_burst.sv
// data_memory_burst: single-port word memory with a valid/ready request
// channel, single and critical-word-first wrapping line-burst reads,
// programmable first-beat latency, response backpressure and an optional
// post-reset clear sequence.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_write, req_burst  : write / burst-read select
//   req_addr, req_wdata   : word address, write data
//   resp_valid/resp_ready : read beat handshake
//   resp_data, resp_last  : read data, final beat flag
//   busy                  : controller is not IDLE
module data_memory_burst
   import dm_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 15,
   parameter int LINE_WORDS   = 4,
   parameter int LATENCY      = 2,
   parameter int INIT_PATTERN = 1,
   parameter int CLEAR_ON_RST = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_burst,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_last,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int OFF_W = clog2(LINE_WORDS);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);

   state_e            state_q,      state_d;
   logic [ADDR_W-1:0] base_q,       base_d;
   logic              burst_q,      burst_d;
   logic [OFF_W-1:0]  beat_q,       beat_d;
   logic [3:0]        cnt_q,        cnt_d;
   logic [ADDR_W-1:0] clr_ptr_q,    clr_ptr_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_last_q,  resp_last_d;
   logic [DATA_W-1:0] resp_data_q,  resp_data_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata;
   logic [OFF_W-1:0]  rd_beat;

   // In BURST the word being loaded is the one after the beat on the bus;
   // in WAIT it is beat 0 (the requested critical word).
   assign rd_beat   = (state_q == ST_BURST) ? beat_q + 1'b1 : beat_q;
   // Keep the line index, wrap the offset inside the line.
   assign mem_raddr = (base_q & ~OFF_MASK) | ((base_q + ADDR_W'(rd_beat)) & OFF_MASK);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no
      // path through the case leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      base_d       = base_q;
      burst_d      = burst_q;
      beat_d       = beat_q;
      cnt_d        = cnt_q;
      clr_ptr_d    = clr_ptr_q;
      resp_valid_d = resp_valid_q;
      resp_last_d  = resp_last_q;
      resp_data_d  = resp_data_q;
      mem_we       = 1'b0;
      mem_waddr    = req_addr;
      mem_wdata    = req_wdata;

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
               clr_ptr_d = '0;
               state_d   = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (req_valid) begin
               if (req_write) begin
                  mem_we = 1'b1;
               end else begin
                  base_d  = req_addr;
                  burst_d = req_burst;
                  beat_d  = '0;
                  cnt_d   = 4'(LATENCY);
                  state_d = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               resp_data_d  = mem_rdata;
               resp_valid_d = 1'b1;
               resp_last_d  = !burst_q;
               state_d      = ST_BURST;
            end
         end

         ST_BURST: begin
            // Nothing moves while the consumer stalls the current beat.
            if (resp_valid_q && resp_ready) begin
               if (resp_last_q) begin
                  resp_valid_d = 1'b0;
                  resp_last_d  = 1'b0;
                  state_d      = ST_IDLE;
               end else begin
                  beat_d      = beat_q + 1'b1;
                  resp_data_d = mem_rdata;
                  resp_last_d = (int'(beat_q) + 2 == LINE_WORDS);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state is updated only with non-blocking assignments so every
   // flop samples the pre-edge values computed above.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
         base_q       <= '0;
         burst_q      <= 1'b0;
         beat_q       <= '0;
         cnt_q        <= '0;
         clr_ptr_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         burst_q      <= burst_d;
         beat_q       <= beat_d;
         cnt_q        <= cnt_d;
         clr_ptr_q    <= clr_ptr_d;
         resp_valid_q <= resp_valid_d;
         resp_last_q  <= resp_last_d;
         resp_data_q  <= resp_data_d;
      end
   end

   // A reset edge must leave the contents untouched.
   dm_array #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .INIT_PATTERN(INIT_PATTERN)
   ) u_array (
      .clk  (clk),
      .we   (mem_we && !rst),
      .waddr(mem_waddr),
      .wdata(mem_wdata),
      .raddr(mem_raddr),
      .rdata(mem_rdata)
   );

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_last  = resp_last_q;
   assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_data_memory_burst.sv
// tb_data_memory_burst: directed bench for data_memory_burst with
// ADDR_W=4, LINE_WORDS=4, LATENCY=2, INIT_PATTERN=1. A second instance
// with CLEAR_ON_RST=1 covers the clear sequencer.
module tb_data_memory_burst;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_write, req_burst, resp_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready, resp_valid, resp_last, busy;
   logic [DATA_W-1:0] resp_data;

   logic              c_rst;
   logic              c_req_valid, c_resp_ready;
   logic [ADDR_W-1:0] c_req_addr;
   logic              c_req_ready, c_resp_valid, c_resp_last, c_busy;
   logic [DATA_W-1:0] c_resp_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_memory_burst #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(4), .LATENCY(2),
      .INIT_PATTERN(1), .CLEAR_ON_RST(0)
   ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_last(resp_last), .busy(busy)
   );

   data_memory_burst #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(4), .LATENCY(2),
      .INIT_PATTERN(1), .CLEAR_ON_RST(1)
   ) u_clr (
      .clk(clk), .rst(c_rst),
      .req_valid(c_req_valid), .req_ready(c_req_ready), .req_write(1'b0),
      .req_burst(1'b0), .req_addr(c_req_addr), .req_wdata('0),
      .resp_valid(c_resp_valid), .resp_ready(c_resp_ready), .resp_data(c_resp_data),
      .resp_last(c_resp_last), .busy(c_busy)
   );

   // Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a read for exactly one accept edge.
   task automatic start_read(input logic [ADDR_W-1:0] addr, input logic burst);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_burst = burst;
      req_addr  = addr;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic expect_beat(input string tag, input logic [31:0] data, input logic last);
      check({tag, "_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_data"},  resp_data,       data);
      check({tag, "_last"},  32'(resp_last),  32'(last));
   endtask

   // Single read, resp_ready high: accept, two wait edges, beat, release.
   task automatic single_read(input string tag, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] data);
      start_read(addr, 1'b0);
      tick();
      tick();
      tick();
      expect_beat(tag, data, 1'b1);
      tick();
      check({tag, "_done"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      c_rst        = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_burst    = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      resp_ready   = 1'b1;
      c_req_valid  = 1'b0;
      c_req_addr   = '0;
      c_resp_ready = 1'b1;
      tick();
      tick();
      rst   = 1'b0;
      c_rst = 1'b0;

      // Reset state
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_last",  32'(resp_last),  32'd0);
      check("rst_resp_data",  resp_data,       32'd0);
      check("rst_req_ready",  32'(req_ready),  32'd1);
      check("rst_busy",       32'(busy),       32'd0);

      // Single read of addr 5: valid exactly 3 edges after accept
      start_read(4'd5, 1'b0);
      check("s5_ready_after_accept", 32'(req_ready), 32'd0);
      check("s5_busy", 32'(busy), 32'd1);
      check("s5_valid_e1", 32'(resp_valid), 32'd0);
      tick();
      check("s5_valid_e2", 32'(resp_valid), 32'd0);
      tick();
      check("s5_valid_e3", 32'(resp_valid), 32'd0);
      tick();
      expect_beat("s5_beat", 32'd5, 1'b1);
      check("s5_ready_during_beat", 32'(req_ready), 32'd0);
      tick();
      check("s5_valid_after", 32'(resp_valid), 32'd0);
      check("s5_ready_after", 32'(req_ready), 32'd1);

      // Burst addr 6 wraps inside line 4..7: 6,7,4,5
      start_read(4'd6, 1'b1);
      tick();
      tick();
      tick();
      expect_beat("b6_0", 32'd6, 1'b0);
      tick();
      expect_beat("b6_1", 32'd7, 1'b0);
      tick();
      expect_beat("b6_2", 32'd4, 1'b0);
      tick();
      expect_beat("b6_3", 32'd5, 1'b1);
      tick();
      check("b6_valid_after", 32'(resp_valid), 32'd0);
      check("b6_busy_after",  32'(busy),       32'd0);

      // Burst addr 8 with a two-cycle stall on beat 2 and a stray request
      start_read(4'd8, 1'b1);
      tick();
      tick();
      tick();
      expect_beat("b8_0", 32'd8, 1'b0);
      tick();
      expect_beat("b8_1", 32'd9, 1'b0);
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 4'd1;
      req_wdata  = 32'h0000_0BAD;
      tick();
      req_valid  = 1'b0;
      req_write  = 1'b0;
      expect_beat("b8_stall1", 32'd9, 1'b0);
      check("b8_stall_ready", 32'(req_ready), 32'd0);
      tick();
      expect_beat("b8_stall2", 32'd9, 1'b0);
      resp_ready = 1'b1;
      tick();
      expect_beat("b8_2", 32'd10, 1'b0);
      tick();
      expect_beat("b8_3", 32'd11, 1'b1);
      tick();
      check("b8_valid_after", 32'(resp_valid), 32'd0);
      single_read("stray_addr1", 4'd1, 32'd1);

      // Back-to-back writes, one per cycle
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 4'd3;
      req_wdata = 32'hDEAD_BEEF;
      tick();
      check("wr_ready_between", 32'(req_ready), 32'd1);
      req_addr  = 4'd4;
      req_wdata = 32'h1234_5678;
      tick();
      req_valid = 1'b0;
      req_write = 1'b0;
      check("wr_ready_after", 32'(req_ready), 32'd1);
      check("wr_no_resp", 32'(resp_valid), 32'd0);
      single_read("rd_addr3", 4'd3, 32'hDEAD_BEEF);
      single_read("rd_addr4", 4'd4, 32'h1234_5678);

      // Reset in the middle of a burst abandons it, contents preserved
      start_read(4'd0, 1'b1);
      tick();
      tick();
      tick();
      expect_beat("br_0", 32'd0, 1'b0);
      tick();
      expect_beat("br_1", 32'd1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("br_valid_after_rst", 32'(resp_valid), 32'd0);
      check("br_ready_after_rst", 32'(req_ready),  32'd1);
      tick();
      check("br_no_more_beats", 32'(resp_valid), 32'd0);
      single_read("br_addr3_kept", 4'd3, 32'hDEAD_BEEF);

      // Clear sequencer instance: busy for exactly DEPTH cycles, then zero
      c_rst = 1'b1;
      tick();
      c_rst = 1'b0;
      check("clr_busy",  32'(c_busy),      32'd1);
      check("clr_ready", 32'(c_req_ready), 32'd0);
      n = 0;
      while (c_busy && n < 100) begin
         tick();
         n++;
      end
      check("clr_cycles", 32'(n), 32'd16);
      c_req_valid = 1'b1;
      c_req_addr  = 4'd7;
      tick();
      c_req_valid = 1'b0;
      n = 0;
      while (!c_resp_valid && n < 20) begin
         tick();
         n++;
      end
      check("clr_rd_valid", 32'(c_resp_valid), 32'd1);
      check("clr_rd_data",  c_resp_data,       32'd0);
      check("clr_rd_last",  32'(c_resp_last),  32'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
